// File: rtl/hazard_sb.sv
// Scoreboard hazard unit: tracks E/M/W writers to produce the D-stage stall and
// forwarding selects, and interlocks HI/LO access against a multi-cycle MD unit.
module hazard_sb #(
    parameter int NREG    = 32,
    parameter int TW      = 2,
    parameter int MUL_CYC = 5,
    parameter int DIV_CYC = 10,
    localparam int AW     = $clog2(NREG),
    localparam int CW     = $clog2(DIV_CYC + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          hold,
    input  logic          D_valid,
    input  logic [AW-1:0] D_rs,
    input  logic [AW-1:0] D_rt,
    input  logic          D_use_rs,
    input  logic          D_use_rt,
    input  logic [TW-1:0] D_tuse_rs,
    input  logic [TW-1:0] D_tuse_rt,
    input  logic          D_wr_en,
    input  logic [AW-1:0] D_wr_addr,
    input  logic [TW-1:0] D_tnew,
    input  logic          D_md_start,
    input  logic          D_md_div,
    input  logic          D_md_use,
    output logic          stall,
    output logic [1:0]    fwd_rs_D,
    output logic [1:0]    fwd_rt_D,
    output logic          md_busy
);

    typedef struct packed {
        logic          v;
        logic [AW-1:0] addr;
        logic [TW-1:0] tnew;
    } slot_t;

    typedef struct packed {
        logic          hit;
        logic [1:0]    code;
        logic [TW-1:0] tnew;
    } match_t;

    slot_t         e_slot_r, m_slot_r, w_slot_r;
    logic [CW-1:0] md_cnt_r;
    match_t        m_rs_s, m_rt_s;
    logic          stall_rs_s, stall_rt_s, stall_md_s, issue_s;

    function automatic slot_t age(input slot_t s);
        slot_t r;
        r      = s;
        r.tnew = (s.tnew == '0) ? '0 : s.tnew - {{(TW-1){1'b0}}, 1'b1};
        return r;
    endfunction

    // Youngest matching writer wins; older matches for the same register are shadowed.
    function automatic match_t lookup(input logic [AW-1:0] x, input logic use_x,
                                      input slot_t e, input slot_t m, input slot_t w);
        match_t r;
        r = '0;
        if (use_x && (x != '0)) begin
            if (e.v && (e.addr == x)) begin
                r.hit = 1'b1; r.code = 2'd1; r.tnew = e.tnew;
            end else if (m.v && (m.addr == x)) begin
                r.hit = 1'b1; r.code = 2'd2; r.tnew = m.tnew;
            end else if (w.v && (w.addr == x)) begin
                r.hit = 1'b1; r.code = 2'd3; r.tnew = w.tnew;
            end else begin
                r = '0;
            end
        end else begin
            r = '0;
        end
        return r;
    endfunction

    // Hazard detection and forwarding selects from frozen/current slot state
    always_comb begin
        m_rs_s     = lookup(D_rs, D_use_rs, e_slot_r, m_slot_r, w_slot_r);
        m_rt_s     = lookup(D_rt, D_use_rt, e_slot_r, m_slot_r, w_slot_r);
        stall_rs_s = m_rs_s.hit && (m_rs_s.tnew > D_tuse_rs);
        stall_rt_s = m_rt_s.hit && (m_rt_s.tnew > D_tuse_rt);
        md_busy    = (md_cnt_r != '0);
        stall_md_s = D_valid && (D_md_start || D_md_use) && md_busy;
        stall      = D_valid && (stall_rs_s || stall_rt_s || stall_md_s);
        issue_s    = D_valid && !stall && !hold;
        fwd_rs_D   = (m_rs_s.hit && (m_rs_s.tnew == '0)) ? m_rs_s.code : 2'd0;
        fwd_rt_D   = (m_rt_s.hit && (m_rt_s.tnew == '0)) ? m_rt_s.code : 2'd0;
    end

    // E/M/W writer tracking; a stalled D enters E as a bubble
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_slot_r <= '0;
            m_slot_r <= '0;
            w_slot_r <= '0;
        end else if (!hold) begin
            w_slot_r      <= age(m_slot_r);
            m_slot_r      <= age(e_slot_r);
            e_slot_r.v    <= issue_s && D_wr_en && (D_wr_addr != '0);
            e_slot_r.addr <= D_wr_addr;
            e_slot_r.tnew <= D_tnew;
        end else begin
            e_slot_r <= e_slot_r;
            m_slot_r <= m_slot_r;
            w_slot_r <= w_slot_r;
        end
    end

    // MD busy countdown; the unit keeps running while the pipeline is held
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_cnt_r <= '0;
        end else if (issue_s && D_md_start) begin
            md_cnt_r <= D_md_div ? CW'(DIV_CYC) : CW'(MUL_CYC);
        end else if (md_cnt_r != '0) begin
            md_cnt_r <= md_cnt_r - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            md_cnt_r <= md_cnt_r;
        end
    end

endmodule

// File: tb/tb_hazard_sb.sv
// Directed bench for hazard_sb: pipeline scenarios with hand-computed stall/forward values.
module tb_hazard_sb;
    logic       clk = 1'b0;
    logic       reset, hold, D_valid;
    logic [4:0] D_rs, D_rt, D_wr_addr;
    logic       D_use_rs, D_use_rt, D_wr_en;
    logic [1:0] D_tuse_rs, D_tuse_rt, D_tnew;
    logic       D_md_start, D_md_div, D_md_use;
    logic       stall, md_busy;
    logic [1:0] fwd_rs_D, fwd_rt_D;
    int         pass_cnt = 0;
    int         total_cnt = 0;
    int         fail_cnt = 0;

    hazard_sb dut (
        .clk(clk), .reset(reset), .hold(hold), .D_valid(D_valid),
        .D_rs(D_rs), .D_rt(D_rt), .D_use_rs(D_use_rs), .D_use_rt(D_use_rt),
        .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt), .D_wr_en(D_wr_en),
        .D_wr_addr(D_wr_addr), .D_tnew(D_tnew), .D_md_start(D_md_start),
        .D_md_div(D_md_div), .D_md_use(D_md_use), .stall(stall),
        .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear();
        D_valid = 1'b0; D_rs = 5'd0; D_rt = 5'd0; D_use_rs = 1'b0; D_use_rt = 1'b0;
        D_tuse_rs = 2'd0; D_tuse_rt = 2'd0; D_wr_en = 1'b0; D_wr_addr = 5'd0;
        D_tnew = 2'd0; D_md_start = 1'b0; D_md_div = 1'b0; D_md_use = 1'b0;
    endtask

    task automatic producer(input logic [4:0] a, input logic [1:0] tn);
        clear();
        D_valid = 1'b1; D_wr_en = 1'b1; D_wr_addr = a; D_tnew = tn;
    endtask

    task automatic reader(input logic [4:0] a, input logic [1:0] tu);
        clear();
        D_valid = 1'b1; D_rs = a; D_use_rs = 1'b1; D_tuse_rs = tu;
    endtask

    task automatic flush();
        clear();
        repeat (4) tick();
    endtask

    initial begin
        clear();
        hold = 1'b0;
        reset = 1'b0;
        #3;
        chk("reset_stall", {3'd0, stall}, 4'd0);
        chk("reset_fwd_rs", {2'd0, fwd_rs_D}, 4'd0);
        chk("reset_md_busy", {3'd0, md_busy}, 4'd0);
        #9 reset = 1'b1;
        tick();

        // lw r3 ; addu r4,r3,r3 -> one stall, then W forward for a later reader
        producer(5'd3, 2'd2);
        #1 chk("lw_issue_stall", {3'd0, stall}, 4'd0);
        tick();
        reader(5'd3, 2'd1);
        D_rt = 5'd3; D_use_rt = 1'b1; D_tuse_rt = 2'd1;
        D_wr_en = 1'b1; D_wr_addr = 5'd4; D_tnew = 2'd1;
        #1 chk("lw_add_stall1", {3'd0, stall}, 4'd1);
        tick();
        #1 chk("lw_add_go", {3'd0, stall}, 4'd0);
        tick();
        reader(5'd3, 2'd0);
        #1 chk("lw_w_fwd", {2'd0, fwd_rs_D}, 4'd3);
        chk("lw_w_stall", {3'd0, stall}, 4'd0);
        flush();

        // jal ; jr r31 -> no stall, forward from E then M
        producer(5'd31, 2'd0);
        tick();
        reader(5'd31, 2'd0);
        #1 chk("jr_stall", {3'd0, stall}, 4'd0);
        chk("jr_fwd_e", {2'd0, fwd_rs_D}, 4'd1);
        tick();
        #1 chk("jr_fwd_m", {2'd0, fwd_rs_D}, 4'd2);
        flush();

        // lw r2 ; ori r2 ; beq r2 -> E (younger) governs
        producer(5'd2, 2'd2);
        tick();
        producer(5'd2, 2'd1);
        tick();
        reader(5'd2, 2'd0);
        D_rt = 5'd2; D_use_rt = 1'b1; D_tuse_rt = 2'd0;
        #1 chk("beq_stall", {3'd0, stall}, 4'd1);
        chk("beq_fwd_wait", {2'd0, fwd_rs_D}, 4'd0);
        tick();
        #1 chk("beq_go", {3'd0, stall}, 4'd0);
        chk("beq_fwd_rs_m", {2'd0, fwd_rs_D}, 4'd2);
        chk("beq_fwd_rt_m", {2'd0, fwd_rt_D}, 4'd2);
        flush();

        // mult ; mflo -> 5 stall cycles
        clear(); D_valid = 1'b1; D_md_start = 1'b1;
        #1 chk("mult_issue", {3'd0, stall}, 4'd0);
        tick();
        clear(); D_valid = 1'b1; D_md_use = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 chk($sformatf("mult_stall_%0d", i), {2'd0, stall, md_busy}, 4'd3);
            tick();
        end
        #1 chk("mult_done", {2'd0, stall, md_busy}, 4'd0);
        tick();

        // div, then a second div waiting until the unit drains (incl. cnt == 1)
        clear(); D_valid = 1'b1; D_md_start = 1'b1; D_md_div = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            #1 chk($sformatf("div_stall_%0d", i), {2'd0, stall, md_busy}, 4'd3);
            tick();
        end
        #1 chk("div2_issue", {2'd0, stall, md_busy}, 4'd0);
        tick();
        clear();
        #1 chk("div2_busy", {3'd0, md_busy}, 4'd1);
        repeat (10) tick();
        #1 chk("div2_drained", {3'd0, md_busy}, 4'd0);
        flush();

        // hold freezes the slots: lw r7 in E, addu r7 waits
        producer(5'd7, 2'd2);
        tick();
        reader(5'd7, 2'd1);
        hold = 1'b1;
        #1 chk("hold_stall_0", {3'd0, stall}, 4'd1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            #1 chk($sformatf("hold_stall_%0d", i), {3'd0, stall}, 4'd1);
        end
        hold = 1'b0;
        #1 chk("unhold_stall", {3'd0, stall}, 4'd1);
        tick();
        #1 chk("unhold_go", {3'd0, stall}, 4'd0);
        flush();

        // async reset mid-divide with lw r5 in E
        clear(); D_valid = 1'b1; D_md_start = 1'b1; D_md_div = 1'b1;
        tick();
        clear();
        repeat (3) tick();
        producer(5'd5, 2'd2);
        tick();
        reader(5'd5, 2'd0);
        #1 chk("pre_rst_stall", {2'd0, stall, md_busy}, 4'd3);
        reset = 1'b0;
        #1 chk("rst_stall", {3'd0, stall}, 4'd0);
        chk("rst_md_busy", {3'd0, md_busy}, 4'd0);
        chk("rst_fwd", {2'd0, fwd_rs_D}, 4'd0);
        #1 reset = 1'b1;
        tick();
        clear(); D_valid = 1'b1; D_md_use = 1'b1;
        #1 chk("post_rst_mduse", {2'd0, stall, md_busy}, 4'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
